// File: rtl/chess_matrix_scanner_if.sv
// Square stream from the chess matrix scanner to its consumer (renderer, move checker).
// Latency: none, this is wiring only.
// Backpressure: consumer holds SquareReady low to stall; producer keeps the square stable.
//
// Ports (master = scanner side):
//   SquareValid, SquareIndex, SquareRow, SquareCol, PieceCode, LastSquare : master -> slave
//   SquareReady                                                           : slave -> master
interface chess_matrix_scanner_if #(
  parameter int SQUARE_WIDTH = 4
);
  logic                    SquareValid;
  logic                    SquareReady;
  logic [5:0]              SquareIndex;
  logic [2:0]              SquareRow;
  logic [2:0]              SquareCol;
  logic [SQUARE_WIDTH-1:0] PieceCode;
  logic                    LastSquare;

  modport master (
    output SquareValid, SquareIndex, SquareRow, SquareCol, PieceCode, LastSquare,
    input  SquareReady
  );

  modport slave (
    input  SquareValid, SquareIndex, SquareRow, SquareCol, PieceCode, LastSquare,
    output SquareReady
  );
endinterface

// File: rtl/chess_matrix_scanner.sv
// Snapshots the packed board on Start and streams squares 0..63, counting occupied squares.
// Latency: first square valid the edge Start is sampled; one square per cycle; Done 1 cycle after last transfer.
// Backpressure: SquareReady low stalls the stream with all square outputs held stable.
//
// Ports:
//   clock, resetApp (sync, active-low)   : clock and reset
//   Matrix [MATRIX_WIDTH]                : live board, square s at bits [4s+3:4s]
//   Start                                : scan request, ignored while a scan is running
//   squareBus (master)                   : square stream with valid/ready handshake
//   Busy, Done, PieceCount               : scan status and occupancy of the last completed scan
module chess_matrix_scanner #(
  parameter int CHESS_SQUARES = 64,
  parameter int SQUARE_WIDTH  = 4,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetApp,
  input  logic [MATRIX_WIDTH-1:0] Matrix,
  input  logic                    Start,
  chess_matrix_scanner_if.master  squareBus,
  output logic                    Busy,
  output logic                    Done,
  output logic [6:0]              PieceCount
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  stateQ;
  state_t                  stateD;

  logic [MATRIX_WIDTH-1:0] shadow;
  logic [5:0]              idx;
  logic [6:0]              cnt;
  logic [6:0]              pieceCountQ;
  logic                    doneQ;

  logic [SQUARE_WIDTH-1:0] curCode;
  logic                    curOccupied;
  logic                    atLast;

  logic                    load;
  logic                    xfer;
  logic                    valid;

  // Square outputs are a pure view of the snapshot at Idx, so they cannot move during a stall.
  assign curCode     = shadow[int'(idx)*SQUARE_WIDTH +: SQUARE_WIDTH];
  assign curOccupied = (curCode != '0);
  assign atLast      = (idx == 6'd63);

  always_comb begin
    stateD = stateQ;
    load   = 1'b0;
    xfer   = 1'b0;
    valid  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (Start) begin
          load   = 1'b1;
          stateD = STREAM;
        end
      end
      STREAM: begin
        valid = 1'b1;
        xfer  = squareBus.SquareReady;
        if (xfer && atLast) begin
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetApp) begin
      stateQ      <= IDLE;
      shadow      <= '0;
      idx         <= '0;
      cnt         <= '0;
      pieceCountQ <= '0;
      doneQ       <= 1'b0;
    end else begin
      stateQ <= stateD;
      doneQ  <= xfer && atLast;
      if (load) begin
        shadow <= Matrix;
        idx    <= '0;
        cnt    <= '0;
      end else if (xfer) begin
        cnt <= cnt + {6'd0, curOccupied};
        if (atLast) begin
          // Include square 63 itself; Idx parks at 63 rather than wrapping.
          pieceCountQ <= cnt + {6'd0, curOccupied};
        end else begin
          idx <= idx + 6'd1;
        end
      end
    end
  end

  assign squareBus.SquareValid = valid;
  assign squareBus.SquareIndex = idx;
  assign squareBus.SquareRow   = idx[5:3];
  assign squareBus.SquareCol   = idx[2:0];
  assign squareBus.PieceCode   = curCode;
  assign squareBus.LastSquare  = valid && atLast;

  assign Busy       = valid;
  assign Done       = doneQ;
  assign PieceCount = pieceCountQ;

endmodule

// File: tb/tb_chess_matrix_scanner.sv
module tb_chess_matrix_scanner;

  localparam int SQ = 64;
  localparam int SW = 4;
  localparam int MW = SQ * SW;

  logic          clock;
  logic          resetApp;
  logic [MW-1:0] Matrix;
  logic          Start;
  logic          Busy;
  logic          Done;
  logic [6:0]    PieceCount;

  chess_matrix_scanner_if #(.SQUARE_WIDTH(SW)) sqIf();

  chess_matrix_scanner #(
    .CHESS_SQUARES(SQ),
    .SQUARE_WIDTH (SW),
    .MATRIX_WIDTH (MW)
  ) dut (
    .clock     (clock),
    .resetApp  (resetApp),
    .Matrix    (Matrix),
    .Start     (Start),
    .squareBus (sqIf),
    .Busy      (Busy),
    .Done      (Done),
    .PieceCount(PieceCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: a scan is a list of 64 codes taken at Start, walked by a position
  // that advances on every accepted square; the result is the number of non-empty entries.
  int mSnap[SQ];
  int mPos   = 0;
  bit mBusy  = 0;
  bit mDone  = 0;
  int mCount = 0;

  always @(posedge clock) begin
    mDone = 0;
    if (!resetApp) begin
      mBusy  = 0;
      mPos   = 0;
      mCount = 0;
      for (int s = 0; s < SQ; s++) mSnap[s] = 0;
    end else if (!mBusy) begin
      if (Start) begin
        for (int s = 0; s < SQ; s++) mSnap[s] = int'(Matrix[s*SW +: SW]);
        mPos  = 0;
        mBusy = 1;
      end
    end else if (sqIf.SquareReady) begin
      if (mPos == SQ - 1) begin
        mBusy  = 0;
        mDone  = 1;
        mCount = 0;
        for (int s = 0; s < SQ; s++) if (mSnap[s] != 0) mCount++;
      end else begin
        mPos++;
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      check("valid", int'(sqIf.SquareValid), int'(mBusy));
      check("busy",  int'(Busy),             int'(mBusy));
      check("done",  int'(Done),             int'(mDone));
      check("last",  int'(sqIf.LastSquare),  int'(mBusy && mPos == SQ - 1));
      check("index", int'(sqIf.SquareIndex), mPos);
      check("row",   int'(sqIf.SquareRow),   mPos / 8);
      check("col",   int'(sqIf.SquareCol),   mPos % 8);
      check("code",  int'(sqIf.PieceCode),   mSnap[mPos]);
      check("count", int'(PieceCount),       mCount);
    end
  end

  function automatic logic [MW-1:0] standardBoard();
    logic [MW-1:0] b;
    int back[8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[(0*8 + c)*SW +: SW] = 4'(back[c]);
      b[(1*8 + c)*SW +: SW] = 4'd1;
      b[(6*8 + c)*SW +: SW] = 4'd9;
      b[(7*8 + c)*SW +: SW] = 4'(back[c] + 8);
    end
    return b;
  endfunction

  // Called at a negedge; raises Start immediately and runs until Done or abort.
  task automatic runScan(input string tag, input bit randReady, input int zeroAt,
                         input bit busyStart, input bit abortAt40,
                         input int expCount, input int expCycles);
    int n;
    bit doneSeen, aborted, pulsed, resetPending;
    n = 0; doneSeen = 0; aborted = 0; pulsed = 0; resetPending = 0;
    Start = 1'b1;
    sqIf.SquareReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    while (n < 3000 && !doneSeen && !aborted) begin
      @(negedge clock);
      n++;
      Start = 1'b0;
      if (resetPending) begin
        resetApp = 1'b1;
        check({tag, " abort valid"}, int'(sqIf.SquareValid), 0);
        check({tag, " abort busy"},  int'(Busy), 0);
        check({tag, " abort count"}, int'(PieceCount), 0);
        check({tag, " abort done"},  int'(Done), 0);
        aborted = 1;
      end else if (Done) begin
        doneSeen = 1;
      end else begin
        if (n == zeroAt) Matrix = '0;
        if (busyStart && !pulsed && sqIf.SquareValid && sqIf.SquareIndex == 6'd10) begin
          Start  = 1'b1;
          pulsed = 1;
        end
        if (abortAt40 && sqIf.SquareValid && sqIf.SquareIndex == 6'd40) begin
          resetApp     = 1'b0;
          resetPending = 1;
        end
        sqIf.SquareReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (abortAt40) begin
      check({tag, " aborted"}, int'(aborted), 1);
    end else begin
      check({tag, " done seen"}, int'(doneSeen), 1);
      check({tag, " piece count"}, int'(PieceCount), expCount);
      if (expCycles > 0) check({tag, " cycles"}, n - 1, expCycles);
    end
  endtask

  task automatic idle(input int cycles);
    sqIf.SquareReady = 1'b1;
    repeat (cycles) @(negedge clock);
  endtask

  int extraDone;

  initial begin
    resetApp = 1'b0;
    Start    = 1'b0;
    Matrix   = '0;
    sqIf.SquareReady = 1'b0;
    repeat (2) @(negedge clock);
    check("reset valid", int'(sqIf.SquareValid), 0);
    check("reset busy",  int'(Busy), 0);
    check("reset done",  int'(Done), 0);
    check("reset last",  int'(sqIf.LastSquare), 0);
    check("reset index", int'(sqIf.SquareIndex), 0);
    check("reset row",   int'(sqIf.SquareRow), 0);
    check("reset col",   int'(sqIf.SquareCol), 0);
    check("reset code",  int'(sqIf.PieceCode), 0);
    check("reset count", int'(PieceCount), 0);
    resetApp = 1'b1;
    checkEn  = 1;
    sqIf.SquareReady = 1'b1;  // ready before valid is harmless
    idle(2);

    Matrix = standardBoard();
    runScan("standard", 0, 0, 0, 0, 32, 64);
    idle(3);
    runScan("backpressure", 1, 0, 0, 0, 32, 0);
    idle(3);
    runScan("snapshot", 0, 5, 0, 0, 32, 64);
    runScan("back-to-back", 0, 0, 0, 0, 0, 64);

    Matrix = standardBoard();
    idle(2);
    runScan("start-busy", 0, 0, 1, 0, 32, 64);
    extraDone = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      if (Done) extraDone++;
    end
    check("start-busy extra done", extraDone, 0);
    check("start-busy idle", int'(Busy), 0);

    runScan("reset-mid", 0, 0, 0, 1, 0, 0);
    extraDone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (Done) extraDone++;
    end
    check("reset-mid no done", extraDone, 0);
    runScan("restart", 0, 0, 0, 0, 32, 64);

    idle(2);
    Matrix = '1;
    runScan("full", 1, 0, 0, 0, 64, 0);
    idle(3);

    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chess_matrix_scanner.md
# chess_matrix_scanner

Read-side companion to the chess layout matrix register. Takes a snapshot of the packed 64-square board matrix on a start request. It then streams the board one square per transfer over a valid/ready handshake, in square order 0..63. The display renderer and the move checker use it to walk the board without decoding the full matrix themselves. While scanning, it also counts occupied squares and reports the total when the scan completes.

## Interface
- CHESS_SQUARES, 64, squares per board
- SQUARE_WIDTH, 4, bits per square piece code
- MATRIX_WIDTH, CHESS_SQUARES*SQUARE_WIDTH, packed matrix width
- clock  in  1  single clock; all logic on rising edge
- resetApp  in  1  reset, synchronous, active-low
- Matrix  in  MATRIX_WIDTH  packed board; square s occupies bits [4s+3:4s]
- Start  in  1  scan request, sampled each edge
- SquareReady  in  1  consumer accepts current square
- SquareValid  out  1  square data valid
- SquareIndex  out  6  current square index s
- SquareRow  out  3  s[5:3]
- SquareCol  out  3  s[2:0]
- PieceCode  out  SQUARE_WIDTH  piece code of square s; 0 = empty
- LastSquare  out  1  high with SquareValid when s = 63
- Busy  out  1  scan in progress
- Done  out  1  one-cycle pulse after final transfer
- PieceCount  out  7  count of non-zero PieceCode transferred in last scan, 0..64

## Operation
- The FSM has two states: IDLE and STREAM.
- Internal registers:
  - Shadow: MATRIX_WIDTH snapshot of Matrix.
  - Idx: 6-bit square counter.
  - Cnt: 7-bit occupancy counter.
- **IDLE, Start=1:**
  - Shadow <= Matrix, Idx <= 0, Cnt <= 0.
  - Go to STREAM.
- **IDLE, Start=0:** hold all registers.
- **STREAM:**
  - SquareValid=1 and Busy=1.
  - PieceCode = Shadow[4*Idx+3:4*Idx]; row and column are decoded from Idx.
  - A transfer happens when SquareValid && SquareReady at an edge.
- **On each transfer:**
  - Cnt <= Cnt + (PieceCode != 0).
  - If Idx != 63, then Idx <= Idx+1.
  - If Idx == 63, then:
    - PieceCount <= final Cnt, including square 63.
    - Done <= 1.
    - Go to IDLE.
- Start is ignored while in STREAM.
- Matrix changes during STREAM do not affect the scan. Only Shadow is read.
- PieceCount holds its value until the next completed scan. It is not cleared by Start.
- Idx does not wrap. Reaching 63 ends the scan.

## Timing
- **Reset (resetApp low at an edge):** after that edge, all of the following hold:
  - FSM = IDLE.
  - SquareValid=0, Busy=0, Done=0, LastSquare=0.
  - SquareIndex=0, SquareRow=0, SquareCol=0, PieceCode=0.
  - PieceCount=0.
  - Shadow is cleared.
- Reset in mid-scan aborts the scan. No Done pulse is generated.
- Reset has priority over Start.
- **Start latency:** Start sampled high at edge N gives SquareValid=1, Busy=1 and SquareIndex=0 from edge N onward.
- **Handshake rules:**
  - While SquareValid=1 and SquareReady=0, all square outputs stay stable.
  - SquareReady is allowed to be high before SquareValid; that is harmless.
- **Throughput:** with SquareReady held high, one square is transferred per cycle. A full scan takes 64 cycles from the first valid to the last transfer.
- **Completion:** final transfer at edge M gives the following after M:
  - SquareValid=0, Busy=0, LastSquare=0.
  - Done=1 and PieceCount updated.
  - After edge M+1, Done=0.
- **Back-to-back scans:** Start high in the Done cycle is accepted (FSM is in IDLE). Back-to-back scans therefore have a 1-cycle gap.
- SquareIndex, row, column and PieceCode are combinational from Idx and Shadow. They are meaningful only while SquareValid=1. When SquareValid=0 they show square Idx of Shadow.

## Test plan
- **Standard layout, Ready tied high:**
  - Stimulus: load the standard initial chess layout (ranks 1,2,7,8 occupied), pulse Start.
  - Response: 64 consecutive transfers with indices 0..63 and PieceCodes matching the nibbles. LastSquare is high only on index 63. Done pulses at 64 cycles after the first valid. PieceCount=32.
- **Backpressure:**
  - Stimulus: toggle SquareReady with a random pattern.
  - Response: outputs stay stable while stalled, no square is skipped or duplicated, and PieceCount is still 32.
- **Snapshot isolation:**
  - Stimulus: change Matrix to all-zero 5 cycles after Start.
  - Response: the streamed codes still match the pre-Start board.
  - Stimulus: follow with a second Start in the Done cycle.
  - Response: second scan returns all zeros and PieceCount=0.
- **Start while busy:**
  - Stimulus: pulse Start at index 10.
  - Response: no restart. Index continues 11, 12, … and there is exactly one Done.
- **Reset mid-scan:**
  - Stimulus: drive resetApp low for one edge at index 40.
  - Response: after that edge, SquareValid=0, Busy=0, PieceCount=0 and there is no Done pulse. A subsequent Start restarts at index 0.
- **Full board:**
  - Stimulus: set every square to 4'hF.
  - Response: PieceCount=64, with no overflow.
